// File: rtl/bsm_pkg.sv
// Shared constants, FSM encodings and metric-vector types for the backward state-metric engine.
package bsm_pkg;

    localparam int W        = 12;
    localparam int NUM_ST   = 8;
    localparam int NUM_BR   = 16;
    localparam int NEG_INIT = -512;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef logic signed [W-1:0]       metric_t;
    typedef logic [NUM_ST*W-1:0]       metric_vec_t;
    typedef logic [NUM_BR*W-1:0]       branch_vec_t;

endpackage

// File: rtl/bsm_acs_array.sv
// Combinational 8-way add-compare-select with normalisation to state 0.
// Define BSM_SAT_EN to saturate each add and the normalising subtract instead of wrapping.
module bsm_acs_array
    import bsm_pkg::*;
(
    input  branch_vec_t gam,
    input  metric_vec_t r,
    output metric_vec_t n
);

`ifdef BSM_SAT_EN
    function automatic metric_t sat(input logic signed [W:0] x);
        // Overflow shows as the two top bits disagreeing.
        if (x[W] != x[W-1]) begin
            return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return x[W-1:0];
    endfunction

    function automatic metric_t madd(input metric_t a, input metric_t b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        return sat(s);
    endfunction

    function automatic metric_t msub(input metric_t a, input metric_t b);
        logic signed [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        return sat(s);
    endfunction
`else
    function automatic metric_t madd(input metric_t a, input metric_t b);
        return a + b;
    endfunction

    function automatic metric_t msub(input metric_t a, input metric_t b);
        return a - b;
    endfunction
`endif

    metric_t g   [NUM_BR];
    metric_t ra  [NUM_ST];
    metric_t c0  [NUM_ST];
    metric_t c1  [NUM_ST];
    metric_t nxt [NUM_ST];

    always_comb begin
        n = '0;
        for (int k = 0; k < NUM_BR; k++) begin
            g[k] = gam[k*W +: W];
        end
        for (int s = 0; s < NUM_ST; s++) begin
            ra[s] = r[s*W +: W];
        end
        // Strict > so a tie picks the g[2s+1] path.
        for (int s = 0; s < NUM_ST; s++) begin
            c0[s]  = madd(g[2*s], ra[s>>1]);
            c1[s]  = madd(g[2*s+1], ra[(s>>1)+4]);
            nxt[s] = (c0[s] > c1[s]) ? c0[s] : c1[s];
        end
        for (int s = 0; s < NUM_ST; s++) begin
            n[s*W +: W] = msub(nxt[s], nxt[0]);
        end
    end

endmodule

// File: rtl/bsm_recursion.sv
// Backward-recursion engine: FSM, step counter, metric registers and a single output register.
// Arithmetic mode (wrap or saturate) follows the BSM_SAT_EN define inside bsm_acs_array.
module bsm_recursion
    import bsm_pkg::*;
#(
    parameter int unsigned LEN_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  blk_len,
    input  logic              term,
    output logic              busy,
    input  logic              gam_valid,
    output logic              gam_ready,
    input  logic [16*W-1:0]   gam,
    output logic              bm_valid,
    input  logic              bm_ready,
    output logic [8*W-1:0]    bm,
    output logic [LEN_W-1:0]  bm_idx,
    output logic              bm_last,
    output logic              done
);

    logic [1:0]       state;
    logic [LEN_W-1:0] cnt;
    metric_vec_t      r;
    metric_vec_t      n;
    metric_vec_t      init_vec;
    logic             gam_hs;

    bsm_acs_array u_acs (
        .gam (gam),
        .r   (r),
        .n   (n)
    );

    assign gam_ready = (state == RUN) && (!bm_valid || bm_ready);
    assign gam_hs    = gam_valid && gam_ready;

    always_comb begin
        init_vec = '0;
        for (int s = 1; s < NUM_ST; s++) begin
            init_vec[s*W +: W] = term ? metric_t'(NEG_INIT) : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            r        <= '0;
            busy     <= 1'b0;
            bm_valid <= 1'b0;
            bm       <= '0;
            bm_idx   <= '0;
            bm_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bm_valid && bm_ready) begin
                bm_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && (blk_len != '0)) begin
                        r     <= init_vec;
                        cnt   <= blk_len - 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (gam_hs) begin
                        r        <= n;
                        bm       <= n;
                        bm_valid <= 1'b1;
                        bm_idx   <= cnt;
                        bm_last  <= (cnt == '0);
                        if (cnt == '0) begin
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bm_valid && bm_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsm_recursion.sv
// Scoreboard bench for bsm_recursion: directed blocks push expected beats, a negedge monitor checks them.
module tb_bsm_recursion;
    import bsm_pkg::*;

    localparam int LW = 10;

    typedef struct {
        logic [8*W-1:0] bm;
        logic [LW-1:0]  idx;
        logic           last;
    } beat_t;

    logic             clock;
    logic             reset;
    logic             start;
    logic [LW-1:0]    blk_len;
    logic             term;
    logic             busy;
    logic             gam_valid;
    logic             gam_ready;
    logic [16*W-1:0]  gam;
    logic             bm_valid;
    logic             bm_ready;
    logic [8*W-1:0]   bm;
    logic [LW-1:0]    bm_idx;
    logic             bm_last;
    logic             done;

    int    nvec = 0;
    int    nerr = 0;
    int    cyc  = 0;
    logic  done_due = 1'b0;
    beat_t sb[$];
    int    hs[$];

    bsm_recursion #(.LEN_W(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .blk_len   (blk_len),
        .term      (term),
        .busy      (busy),
        .gam_valid (gam_valid),
        .gam_ready (gam_ready),
        .gam       (gam),
        .bm_valid  (bm_valid),
        .bm_ready  (bm_ready),
        .bm        (bm),
        .bm_idx    (bm_idx),
        .bm_last   (bm_last),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [8*W-1:0] mk(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
        int t[8];
        logic [8*W-1:0] v;
        t = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int s = 0; s < 8; s++) begin
            v[s*W +: W] = t[s][W-1:0];
        end
        return v;
    endfunction

    function automatic beat_t bt(input logic [8*W-1:0] m, input int idx, input logic last);
        beat_t b;
        b.bm   = m;
        b.idx  = idx[LW-1:0];
        b.last = last;
        return b;
    endfunction

    task automatic set_gam_ramp();
        for (int k = 0; k < 16; k++) begin
            gam[k*W +: W] = k[W-1:0];
        end
    endtask

    task automatic pulse_start(input int len, input logic t);
        @(posedge clock); #1;
        start   = 1'b1;
        blk_len = len[LW-1:0];
        term    = t;
        @(posedge clock); #1;
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) break;
        end
        if (i == 200) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: got %0d beats pending, want 0", name, sb.size());
        end
        repeat (2) @(negedge clock);
    endtask

    // Monitor: done must follow the last accepted beat by exactly one cycle.
    always @(negedge clock) begin
        beat_t e;
        cyc++;
        if (done_due || done) chk("done", 96'(done), 96'(done_due));
        done_due = 1'b0;
        if (!reset && bm_valid && bm_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_beat: got idx %0d, want no beat", bm_idx);
            end else begin
                e = sb.pop_front();
                chk("bm", 96'(bm), 96'(e.bm));
                chk("bm_idx", 96'(bm_idx), 96'(e.idx));
                chk("bm_last", 96'(bm_last), 96'(e.last));
                hs.push_back(cyc);
                if (e.last) done_due = 1'b1;
            end
        end
    end

    initial begin
        logic [8*W-1:0] held;
        int i;
        reset = 1'b1; start = 1'b0; blk_len = '0; term = 1'b0;
        gam_valid = 1'b0; gam = '0; bm_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_gam_ready", 96'(gam_ready), 96'(0));
        chk("rst_bm_valid", 96'(bm_valid), 96'(0));
        chk("rst_bm", 96'(bm), 96'(0));
        chk("rst_bm_idx", 96'(bm_idx), 96'(0));
        chk("rst_bm_last", 96'(bm_last), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        // Terminated single step, all branch metrics zero.
        gam = '0; bm_ready = 1'b1; gam_valid = 1'b1;
        sb.push_back(bt(mk(0, 0, -512, -512, -512, -512, -512, -512), 0, 1'b1));
        pulse_start(1, 1'b1);
        wait_idle("term_step");
        gam_valid = 1'b0;

        // Three-step stream with g[k]=k; a stray start during RUN must be ignored.
        set_gam_ramp();
        hs.delete();
        sb.push_back(bt(mk(0, 2, 4, 6, 8, 10, 12, 14), 2, 1'b0));
        sb.push_back(bt(mk(0, 2, 6, 8, 12, 14, 18, 20), 1, 1'b0));
        sb.push_back(bt(mk(0, 2, 6, 8, 14, 16, 20, 22), 0, 1'b1));
        gam_valid = 1'b1;
        pulse_start(3, 1'b0);
        pulse_start(5, 1'b1);
        wait_idle("stream");
        gam_valid = 1'b0;
        if (hs.size() == 3) begin
            chk("gap01", 96'(hs[1] - hs[0]), 96'(1));
            chk("gap12", 96'(hs[2] - hs[1]), 96'(1));
        end else begin
            nvec++;
            nerr++;
            $display("FAIL beat_count: got %0d, want 3", hs.size());
        end

        // Backpressure: hold the first beat for 5 cycles.
        bm_ready = 1'b0;
        sb.push_back(bt(mk(0, 2, 4, 6, 8, 10, 12, 14), 2, 1'b0));
        sb.push_back(bt(mk(0, 2, 6, 8, 12, 14, 18, 20), 1, 1'b0));
        sb.push_back(bt(mk(0, 2, 6, 8, 14, 16, 20, 22), 0, 1'b1));
        gam_valid = 1'b1;
        pulse_start(3, 1'b0);
        for (i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bm_valid) break;
        end
        held = mk(0, 2, 4, 6, 8, 10, 12, 14);
        chk("bp_valid", 96'(bm_valid), 96'(1));
        repeat (5) begin
            chk("bp_gam_ready", 96'(gam_ready), 96'(0));
            chk("bp_bm_hold", 96'(bm), 96'(held));
            chk("bp_idx_hold", 96'(bm_idx), 96'(2));
            @(negedge clock);
        end
        @(posedge clock); #1;
        bm_ready = 1'b1;
        wait_idle("backpressure");
        gam_valid = 1'b0;

        // Overflow: wrap gives +1, saturation pins at the negative rail.
        for (int k = 0; k < 16; k++) gam[k*W +: W] = 12'h800;
        gam[0 +: W] = 12'h7ff;
        gam[W +: W] = 12'h000;
`ifdef BSM_SAT_EN
        sb.push_back(bt(mk(0, -2048, -2048, -2048, -2048, -2048, -2048, -2048), 0, 1'b1));
`else
        sb.push_back(bt(mk(0, 1, 1, 1, 1, 1, 1, 1), 0, 1'b1));
`endif
        gam_valid = 1'b1;
        pulse_start(1, 1'b0);
        wait_idle("overflow");
        gam_valid = 1'b0;

        // Zero-length start is ignored.
        pulse_start(0, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("len0_busy", 96'(busy), 96'(0));
            chk("len0_gam_ready", 96'(gam_ready), 96'(0));
        end

        // Reset mid-block: outputs clear and no done follows.
        set_gam_ramp();
        bm_ready = 1'b0;
        gam_valid = 1'b1;
        pulse_start(3, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_busy", 96'(busy), 96'(0));
        chk("mid_rst_gam_ready", 96'(gam_ready), 96'(0));
        chk("mid_rst_bm_valid", 96'(bm_valid), 96'(0));
        chk("mid_rst_bm", 96'(bm), 96'(0));
        chk("mid_rst_bm_idx", 96'(bm_idx), 96'(0));
        chk("mid_rst_bm_last", 96'(bm_last), 96'(0));
        #1;
        reset = 1'b0;
        gam_valid = 1'b0;
        bm_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("mid_rst_no_done", 96'(done), 96'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bsm_recursion.md
Name: bsm_recursion

Overview:
- Sequential backward-recursion engine for the 8-state max-log-MAP decoder.
- Holds the 8 backward state metrics in registers and consumes one trellis step of 16 branch metrics per handshake.
- Computes next metrics with an add-compare-select array, normalises them, and streams them to the LLR stage with a valid/ready interface.
- Sits between the branch-metric unit (upstream) and the LLR/metric-store stage (downstream).

Parameters:
W, 12, signed metric width
LEN_W, 10, width of block length / step index
NEG_INIT, -512, initial metric of non-zero states for a terminated trellis

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a block
blk_len  in  LEN_W  trellis steps in block, sampled on start
term  in  1  1 = terminated trellis, sampled on start
busy  out  1  high from accepted start until done
gam_valid  in  1  branch metrics valid
gam_ready  out  1  engine accepts branch metrics
gam  in  16*W  branch metrics g[0..15], g[k] at bits [k*W +: W]
bm_valid  out  1  normalised metrics valid
bm_ready  in  1  downstream accepts
bm  out  8*W  normalised metrics m[0..7], m[s] at bits [s*W +: W]
bm_idx  out  LEN_W  trellis step of bm
bm_last  out  1  bm is step 0, the final beat
done  out  1  one-cycle pulse after last beat is accepted

Behaviour:
- Reset: FSM=IDLE; busy, gam_ready, bm_valid, bm_last, done=0; bm, bm_idx, metric regs, step counter=0. Reset mid-block aborts it with no done pulse.
- FSM states IDLE, RUN, DRAIN.
- IDLE, start=1, blk_len!=0:
  - Metric regs load r[0]=0; r[1..7]=NEG_INIT if term=1, else 0.
  - cnt=blk_len-1; busy=1; go to RUN.
  - start with blk_len=0 is ignored.
- start in RUN or DRAIN is ignored.
- RUN:
  - gam_ready = !bm_valid || bm_ready (single output register, full throughput).
  - On gam_valid && gam_ready:
    - Compute nxt[s] = max(g[2s]+r[s>>1], g[2s+1]+r[(s>>1)+4]) for s=0..7.
    - Normalise: n[s] = nxt[s] - nxt[0].
    - Next cycle: r and bm get n; bm_valid=1; bm_idx=cnt; bm_last=(cnt==0).
    - If cnt==0, go to DRAIN; else cnt=cnt-1.
- Latency: exactly 1 cycle from gam handshake to bm_valid.
- Output hold: while bm_valid && !bm_ready, bm, bm_idx and bm_last are held stable. bm_valid falls after acceptance unless a new step is accepted in the same cycle.
- Compare is signed strict >. On a tie, the second candidate (g[2s+1] path) is selected.
- Step index counts down from blk_len-1 to 0 (backward order).
- m[0] on bm is always 0.
- DRAIN: gam_ready=0. On bm_valid && bm_ready: done=1 for one cycle, busy=0, go to IDLE.
- Default arithmetic: adds and normalisation subtraction are W-bit two's-complement wrap.

Optional Feature:
BSM_SAT_EN
- Defined: each add and the normalisation subtract is computed at W+1 bits and saturated to [-2^(W-1), 2^(W-1)-1] before compare / register.
- Undefined: plain W-bit wrap; no extra logic.

Decomposition:
- Package bsm_pkg holds:
  - W, NUM_ST=8, NUM_BR=16, NEG_INIT
  - FSM state enum {IDLE, RUN, DRAIN}
  - packed metric-vector typedefs
- Sub-module bsm_acs_array: combinational 8-way ACS plus normalise, with the BSM_SAT_EN switch inside it.
- bsm_recursion owns the FSM, counter, metric regs and output register.

Test Plan:
- Terminated step: term=1, blk_len=1, all g=0 -> bm = [0,0,-512,-512,-512,-512,-512,-512], bm_idx=0, bm_last=1; done one cycle after the bm handshake.
- Three-step stream: term=0, blk_len=3, g[k]=k, bm_ready=1 -> three beats on consecutive cycles with bm_idx 2,1,0 and bm_last only on idx 0. Each beat must equal the reference model applied step by step.
- Backpressure: bm_ready=0 for 5 cycles mid-block -> gam_ready=0, bm stable and no step lost. Resume with bm_ready=1 -> remaining steps delivered in order.
- Overflow: term=0, g[0]=2047, g[1]=0, all other g=-2048:
  - Without BSM_SAT_EN: m[1..7] = 1 (wrap).
  - With BSM_SAT_EN: m[1..7] = -2048.
- Control edges:
  - start during RUN -> ignored, block completes normally.
  - start with blk_len=0 -> busy stays 0.
  - reset asserted during RUN -> all outputs 0 next cycle and no done pulse.
